// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM states and HI/LO write-enable encodings for the mul/div unit
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam logic [1:0] HILO_WE_HI   = 2'b10;
  localparam logic [1:0] HILO_WE_LO   = 2'b01;
  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between execute stage and the mul/div unit
interface mul_div_unit_if;

  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        busy_o;
  logic [1:0]  hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  busy_o, hilo_we_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output busy_o, hilo_we_o, hi_o, lo_o
  );

endinterface

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - restoring divider datapath, one quotient bit per step, MSB first
module mdu_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo_next,
  output logic [31:0] rem_next
);

  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dsr;
  logic [32:0] part;
  logic        ge;

  // The remainder never reaches the divisor, so 32 bits of storage suffice;
  // the 33-bit shifted partial remainder only exists during the compare.
  assign part     = {rem, quo[31]};
  assign ge       = part >= {1'b0, dsr};
  assign rem_next = ge ? (part[31:0] - dsr) : part[31:0];
  assign quo_next = {quo[30:0], ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dsr <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dsr <= divisor;
    end else if (step) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MULT/DIV/MTHI/MTLO unit producing HI/LO write pulses
module mul_div_unit
  import mdu_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  state_t      state;
  logic [4:0]  cnt;
  logic        neg_a_q;
  logic        neg_b_q;
  logic        div0_q;
  logic [31:0] a_raw_q;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [1:0]  we_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        is_signed, is_mul, is_div, neg_a, neg_b, accept;
  logic [31:0] a_mag, b_mag;
  logic [63:0] mul_sum, prod;
  logic [31:0] quo_next, rem_next, quo_fix, rem_fix;

  assign is_signed = (bus.op_i == MDU_MULT) || (bus.op_i == MDU_DIV);
  assign is_mul    = (bus.op_i == MDU_MULT) || (bus.op_i == MDU_MULTU);
  assign is_div    = (bus.op_i == MDU_DIV)  || (bus.op_i == MDU_DIVU);
  assign neg_a     = is_signed & bus.a_i[31];
  assign neg_b     = is_signed & bus.b_i[31];
  assign a_mag     = neg_a ? (~bus.a_i + 32'd1) : bus.a_i;
  assign b_mag     = neg_b ? (~bus.b_i + 32'd1) : bus.b_i;
  assign accept    = (state == IDLE) && bus.start_i && !bus.flush_i;

  // Final step is folded into the sign fix so results are registered entering DONE.
  assign mul_sum = acc + (mplier[0] ? mcand : 64'd0);
  assign prod    = (neg_a_q ^ neg_b_q) ? (~mul_sum + 64'd1) : mul_sum;
  assign quo_fix = (neg_a_q ^ neg_b_q) ? (~quo_next + 32'd1) : quo_next;
  assign rem_fix = neg_a_q ? (~rem_next + 32'd1) : rem_next;

  mdu_divider u_divider (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && is_div),
    .step     (state == DIV),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div0_q  <= 1'b0;
      a_raw_q <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      we_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
      cnt   <= '0;
      we_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            div0_q  <= (bus.b_i == 32'd0);
            a_raw_q <= bus.a_i;
            acc     <= '0;
            mcand   <= {32'd0, a_mag};
            mplier  <= b_mag;
            if (is_mul) begin
              state <= MUL;
              cnt   <= 5'd31;
            end else if (is_div) begin
              state <= DIV;
              cnt   <= 5'd31;
            end else begin
              state <= DONE;
              case (bus.op_i)
                MDU_MTHI: begin we_q <= HILO_WE_HI; hi_q <= bus.a_i; end
                MDU_MTLO: begin we_q <= HILO_WE_LO; lo_q <= bus.a_i; end
                default:  we_q <= '0;
              endcase
            end
          end
        end
        MUL: begin
          if (cnt == 5'd0) begin
            state <= DONE;
            we_q  <= HILO_WE_BOTH;
            hi_q  <= prod[63:32];
            lo_q  <= prod[31:0];
          end else begin
            cnt    <= cnt - 5'd1;
            acc    <= mul_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        DIV: begin
          if (cnt == 5'd0) begin
            state <= DONE;
            we_q  <= HILO_WE_BOTH;
            hi_q  <= div0_q ? a_raw_q : rem_fix;
            lo_q  <= div0_q ? 32'hFFFF_FFFF : quo_fix;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          we_q  <= '0;
          hi_q  <= '0;
          lo_q  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o    = (state != IDLE);
  assign bus.hilo_we_o = we_q & {2{~bus.flush_i}};
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] exp_we,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_busy, input int exp_cyc, input int inject_k);
    int busy_n = 0;
    int pulses = 0;
    int cyc = 0;
    logic [1:0]  we = '0;
    logic [31:0] hi = '0;
    logic [31:0] lo = '0;
    @(negedge clk);
    bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == inject_k) begin
        bus.op_i = 3'b100; bus.a_i = 32'hDEAD; bus.start_i = 1'b1;
      end else begin
        bus.start_i = 1'b0;
      end
      #1;
      if (bus.busy_o) busy_n++;
      if (bus.hilo_we_o != 2'b00) begin
        pulses++; we = bus.hilo_we_o; hi = bus.hi_o; lo = bus.lo_o; cyc = k;
      end
    end
    check({name, " we"}, 64'(we), 64'(exp_we));
    check({name, " hi"}, 64'(hi), 64'(exp_hi));
    check({name, " lo"}, 64'(lo), 64'(exp_lo));
    check({name, " busy cycles"}, 64'(busy_n), 64'(exp_busy));
    check({name, " pulse cycle"}, 64'(cyc), 64'(exp_cyc));
    check({name, " pulse count"}, 64'(pulses), (exp_we != 2'b00) ? 64'd1 : 64'd0);
  endtask

  task automatic run_abort(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int abort_k, input bit use_rst);
    int pulses = 0;
    @(negedge clk);
    bus.op_i = op; bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == abort_k) begin
        if (use_rst) rst = 1'b1; else bus.flush_i = 1'b1;
      end else if (k == abort_k + 1) begin
        rst = 1'b0; bus.flush_i = 1'b0;
      end
      #1;
      if (bus.hilo_we_o != 2'b00) pulses++;
      if (k == abort_k) check({name, " busy before abort"}, 64'(bus.busy_o), 64'd1);
      if (k == abort_k + 1) begin
        check({name, " busy after abort"}, 64'(bus.busy_o), 64'd0);
        if (use_rst) check({name, " hi/lo after rst"}, {bus.hi_o, bus.lo_o}, 64'd0);
      end
    end
    check({name, " no write"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.op_i = '0; bus.a_i = '0; bus.b_i = '0; bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(bus.busy_o), 64'd0);
    check("reset we", 64'(bus.hilo_we_o), 64'd0);
    check("reset hi/lo", {bus.hi_o, bus.lo_o}, 64'd0);

    run_op("mult -2*3",     3'b000, 32'hFFFF_FFFE, 32'd3,         2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33, 33, 0);
    run_op("multu max*max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 32'h0000_0001, 33, 33, 0);
    run_op("mult 7*-3",     3'b000, 32'd7,         32'hFFFF_FFFD, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 33, 0);
    run_op("div -7/2",      3'b010, 32'hFFFF_FFF9, 32'd2,         2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33, 0);
    run_op("div 7/-2",      3'b010, 32'd7,         32'hFFFF_FFFE, 2'b11, 32'h0000_0001, 32'hFFFF_FFFD, 33, 33, 0);
    run_op("divu 100/7",    3'b011, 32'd100,       32'd7,         2'b11, 32'd2,         32'd14,        33, 33, 0);
    run_op("divu 7/0",      3'b011, 32'd7,         32'd0,         2'b11, 32'd7,         32'hFFFF_FFFF, 33, 33, 0);
    run_op("div -5/0",      3'b010, 32'hFFFF_FFFB, 32'd0,         2'b11, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33, 33, 0);
    run_op("div min/-1",    3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'd0,         32'h8000_0000, 33, 33, 0);
    run_op("mthi",          3'b100, 32'h1234_5678, 32'hAAAA_AAAA, 2'b10, 32'h1234_5678, 32'd0,         1,  1,  0);
    run_op("mtlo",          3'b101, 32'h1234_5678, 32'hAAAA_AAAA, 2'b01, 32'd0,         32'h1234_5678, 1,  1,  0);
    run_op("noop",          3'b110, 32'h1234_5678, 32'd1,         2'b00, 32'd0,         32'd0,         1,  0,  0);
    run_op("start ignored", 3'b000, 32'd2,         32'd3,         2'b11, 32'd0,         32'd6,         33, 33, 5);

    run_abort("div flush",      3'b010, 32'd1000, 32'd3, 10, 1'b0);
    run_abort("div rst",        3'b010, 32'd1000, 32'd3, 20, 1'b1);
    run_abort("div flush done", 3'b010, 32'd1000, 32'd3, 33, 1'b0);
    run_abort("mthi flush done", 3'b100, 32'h55, 32'd0, 1, 1'b0);

    run_op("mult after abort", 3'b000, 32'd5, 32'd6, 2'b11, 32'd0, 32'd30, 33, 33, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide unit feeding the HI/LO register pair. It sits in the execute stage beside the ALU, accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests, and produces the 2-bit HI/LO write-enable and data words the HI/LO register consumes. It asserts busy while working so the pipeline can stall dependent MFHI/MFLO and new requests.

## Interface

- No parameters. Data width is fixed at 32; the product/quotient pair is 64 bits.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- start_i  in  1  request valid; sampled only in IDLE
- op_i  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops: accepted, no write
- a_i  in  32  multiplicand / dividend / MTHI-MTLO source
- b_i  in  32  multiplier / divisor; ignored for MTHI/MTLO
- flush_i  in  1  cancel any operation; no write results
- busy_o  out  1  high whenever state is not IDLE
- hilo_we_o  out  2  bit1 = write HI, bit0 = write LO; pulses for one cycle
- hi_o  out  32  HI write data; 0 when hilo_we_o[1]=0
- lo_o  out  32  LO write data; 0 when hilo_we_o[0]=0

## Operation

- States: IDLE, MUL, DIV, DONE.
- IDLE with start_i=1 and flush_i=0 accepts the request:
  - Signed ops latch operand magnitudes plus sign flags.
  - MUL/DIV ops load a 5-bit counter to 31 and go to MUL or DIV.
  - MTHI/MTLO/no-op go straight to DONE with the result preloaded.
- MUL: radix-2 shift-add on magnitudes, one multiplier bit per cycle, LSB first, 64-bit accumulator. Go to DONE when the counter is 0; otherwise decrement.
- DIV: restoring division, one quotient bit per cycle, MSB first, 33-bit partial remainder. Same counter rule.
- DONE: apply the sign fix, drive hilo_we_o for one cycle, return to IDLE.
- Sign rules:
  - Signed product is negated (two's complement, 64 bits) when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned ops apply no fix.
- Results:
  - MULT/MULTU: HI = product[63:32], LO = product[31:0], we = 11.
  - DIV/DIVU: LO = quotient, HI = remainder, we = 11.
  - MTHI: hi_o = a_i, we = 10. MTLO: lo_o = a_i, we = 01. No-op: we = 00.
- Divide by zero: LO = 0xFFFFFFFF, HI = a_i, no sign fix, normal latency, we = 11.
- 0x80000000 / -1 (DIV): LO = 0x80000000, HI = 0.
- start_i while busy_o=1 is ignored. No queueing; the requester must hold or retry.

## Timing

- Reset: state IDLE, counter 0, busy_o = 0, hilo_we_o = 00, hi_o = lo_o = 0, all internal registers cleared.
- Request accepted at edge T:
  - MTHI/MTLO/no-op: busy_o high in cycle T+1 only; hilo_we_o pulses in cycle T+1.
  - MUL/DIV: busy_o high for cycles T+1..T+33; hilo_we_o pulses in cycle T+33.
- A new request can be accepted on the edge ending the DONE cycle only if the state is already IDLE; DONE is always followed by at least one IDLE cycle.
- flush_i=1 in any state: next state IDLE, no write pulse. This includes the DONE cycle, where hilo_we_o is forced to 00 combinationally by flush_i.
- flush_i and start_i together in IDLE: flush wins, nothing is accepted.
- rst mid-operation: abort immediately, no write, all reset values on the next cycle.
- All outputs except the flush gating of hilo_we_o are registered.

## Structure

- Package mdu_pkg holds:
  - Op code constants MDU_MULT..MDU_MTLO.
  - State enum (IDLE, MUL, DIV, DONE).
  - HILO_WE_HI = 2'b10, HILO_WE_LO = 2'b01, HILO_WE_BOTH = 2'b11.
- One sub-module, mdu_divider, is natural: the restoring-division datapath (partial remainder, quotient shift register, one-step subtract). It is controlled by the top-level FSM and counter.
- Multiplier datapath, sign handling and FSM live in the top level.

## Test plan

- MULT a=0xFFFFFFFE (-2), b=3 -> at T+33: we=11, HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy_o high exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=7.
- MTHI a=0x12345678 -> T+1: we=10, hi_o=0x12345678, lo_o=0. Repeat with MTLO -> we=01, lo_o=0x12345678, hi_o=0. Second start during busy_o -> ignored.
- DIV started, flush_i at T+10 -> IDLE at T+11, no we pulse ever. Repeat with rst at T+20 and with flush_i during DONE -> no write.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
